// File: rtl/matmul_pkg.sv
// Shared types for the matmul operand feed scheduler.
//   fsm_state_e : scheduler states (StIdle, StRun, StDrain)
//   beat_t      : one paired A/B operand beat, MM_DATA_WIDTH bits per operand
//   tile_dim()  : tile edge length from its log2 width (Si, Sj)
package matmul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } fsm_state_e;

    localparam int unsigned MM_DATA_WIDTH = 64;

    typedef struct packed {
        logic [MM_DATA_WIDTH-1:0] a;
        logic [MM_DATA_WIDTH-1:0] b;
    } beat_t;

    function automatic int unsigned tile_dim(input int unsigned num_width);
        return 32'd1 << num_width;
    endfunction

endpackage

// File: rtl/matmul_feed_fifo.sv
// Two-entry beat FIFO with the head held in a register.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i this cycle (caller guarantees space)
//   wdata_i       : beat to enqueue
//   ready_i       : downstream accept; head pops when valid_o && ready_i
//   head_o        : oldest beat, stable until popped
//   valid_o       : FIFO not empty
//   count_o       : current occupancy (0..2)
module matmul_feed_fifo
    import matmul_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  beat_t      wdata_i,
    input  logic       ready_i,
    output beat_t      head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    logic [1:0] count_q, count_d;
    beat_t      slot0_q, slot0_d, slot1_q, slot1_d;
    logic       pop;
    logic [1:0] widx;

    assign valid_o = (count_q != 2'd0);
    assign pop     = valid_o && ready_i;
    assign head_o  = slot0_q;
    assign count_o = count_q;

    // Slot 0 is always the head; a pop shifts slot 1 down, and the push
    // lands in the first free slot after that shift.
    always_comb begin
        count_d = count_q + {1'b0, push_i} - {1'b0, pop};
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        widx    = count_q - {1'b0, pop};
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (push_i) begin
            if (widx == 2'd0) begin
                slot0_d = wdata_i;
            end else begin
                slot1_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/matmul_feed_sched.sv
// Operand feed scheduler: reads NxN row-major A and B memories and streams paired
// beats in tile order (i, j, n, ii with ii fastest): A[i*Si+ii][n], B[n][j*Sj+ii].
// Optional build macro MATMUL_FEED_PERF_EN adds the stall_cnt output.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, N_in         : run request (sampled in idle) and matrix dimension
//   busy, done, cfg_err : running, end-of-run pulse, illegal-N pulse
//   a_rd_*, b_rd_*      : operand memory read ports, 1-cycle read latency
//   A_out/B_out/_valid  : paired output beat, accepted when valid && out_ready
//   stall_cnt           : (perf builds) cycles with valid high and out_ready low
module matmul_feed_sched
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned PE_NUM_WIDTH = 2,
    parameter int unsigned A_NUM_WIDTH  = 3,
    parameter int unsigned B_NUM_WIDTH  = 3,
    parameter int unsigned N_MAX_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   a_rd_en,
    output logic [ADDR_WIDTH-1:0]  a_rd_addr,
    input  logic [DATA_WIDTH-1:0]  a_rd_data,
    output logic                   b_rd_en,
    output logic [ADDR_WIDTH-1:0]  b_rd_addr,
    input  logic [DATA_WIDTH-1:0]  b_rd_data,
    output logic [DATA_WIDTH-1:0]  A_out,
    output logic                   A_valid_out,
    output logic [DATA_WIDTH-1:0]  B_out,
    output logic                   B_valid_out,
    input  logic                   out_ready
`ifdef MATMUL_FEED_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned Si = tile_dim(A_NUM_WIDTH);
    localparam int unsigned Sj = tile_dim(B_NUM_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] SiA   = ADDR_WIDTH'(Si);
    localparam logic [ADDR_WIDTH-1:0] SiM1A = ADDR_WIDTH'(Si - 1);
    localparam logic [2*N_MAX_WIDTH-1:0] NsqLimit = (2*N_MAX_WIDTH)'(1) << ADDR_WIDTH;

    // B columns advance by the A row step, so the tile must be square.
    if (Sj != Si) begin : g_bad_tile
        $error("B_NUM_WIDTH must equal A_NUM_WIDTH");
    end
    if (DATA_WIDTH != MM_DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must match matmul_pkg::MM_DATA_WIDTH");
    end
    // More PEs than tile elements leaves PEs with nothing to consume.
    if (PE_NUM_WIDTH > A_NUM_WIDTH + B_NUM_WIDTH) begin : g_bad_pe
        $error("PE_NUM_WIDTH exceeds tile size");
    end

    fsm_state_e             state_q;
    logic [N_MAX_WIDTH-1:0] n_max_q, nt_q, n_q, j_q, i_q;
    logic [A_NUM_WIDTH-1:0] ii_q;
    logic [ADDR_WIDTH-1:0]  n_step_q, tile_step_q;
    logic [ADDR_WIDTH-1:0]  a_addr_q, a_n_base_q, a_i_base_q;
    logic [ADDR_WIDTH-1:0]  b_addr_q, b_j_base_q;
    logic                   ret_q;
    logic                   done_q, cfg_err_q;

    logic [2*N_MAX_WIDTH-1:0] n_sq;
    logic                     cfg_legal;
    logic                     ii_last, n_last, j_last, i_last;
    logic [1:0]               fifo_count;
    beat_t                    fifo_head;

    assign n_sq      = {{N_MAX_WIDTH{1'b0}}, N_in} * {{N_MAX_WIDTH{1'b0}}, N_in};
    assign cfg_legal = (N_in != '0) && (N_in[A_NUM_WIDTH-1:0] == '0) && (n_sq <= NsqLimit);

    assign ii_last = &ii_q;
    assign n_last  = (n_q == n_max_q);
    assign j_last  = (j_q == nt_q);
    assign i_last  = (i_q == nt_q);

    // ret_q marks a read whose data arrives this cycle; it already owns a FIFO slot.
    assign a_rd_en   = (state_q == StRun) && (({1'b0, fifo_count} + {2'b00, ret_q}) < 3'd2);
    assign b_rd_en   = a_rd_en;
    assign a_rd_addr = a_addr_q;
    assign b_rd_addr = b_addr_q;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            n_max_q     <= '0;
            nt_q        <= '0;
            n_q         <= '0;
            j_q         <= '0;
            i_q         <= '0;
            ii_q        <= '0;
            n_step_q    <= '0;
            tile_step_q <= '0;
            a_addr_q    <= '0;
            a_n_base_q  <= '0;
            a_i_base_q  <= '0;
            b_addr_q    <= '0;
            b_j_base_q  <= '0;
            ret_q       <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            ret_q     <= a_rd_en;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_legal) begin
                            state_q     <= StRun;
                            n_max_q     <= N_in - N_MAX_WIDTH'(1);
                            nt_q        <= (N_in >> A_NUM_WIDTH) - N_MAX_WIDTH'(1);
                            n_step_q    <= N_in[ADDR_WIDTH-1:0];
                            tile_step_q <= N_in[ADDR_WIDTH-1:0] << A_NUM_WIDTH;
                            n_q         <= '0;
                            j_q         <= '0;
                            i_q         <= '0;
                            ii_q        <= '0;
                            a_addr_q    <= '0;
                            a_n_base_q  <= '0;
                            a_i_base_q  <= '0;
                            b_addr_q    <= '0;
                            b_j_base_q  <= '0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (a_rd_en) begin
                        if (!ii_last) begin
                            ii_q     <= ii_q + A_NUM_WIDTH'(1);
                            a_addr_q <= a_addr_q + n_step_q;
                            b_addr_q <= b_addr_q + ADDR_WIDTH'(1);
                        end else begin
                            ii_q <= '0;
                            if (!n_last) begin
                                // A steps to the next column of the tile's first row;
                                // B steps from the tile row end to the next row start.
                                n_q        <= n_q + N_MAX_WIDTH'(1);
                                a_n_base_q <= a_n_base_q + ADDR_WIDTH'(1);
                                a_addr_q   <= a_n_base_q + ADDR_WIDTH'(1);
                                b_addr_q   <= b_addr_q + n_step_q - SiM1A;
                            end else begin
                                n_q <= '0;
                                if (!j_last) begin
                                    j_q        <= j_q + N_MAX_WIDTH'(1);
                                    a_n_base_q <= a_i_base_q;
                                    a_addr_q   <= a_i_base_q;
                                    b_j_base_q <= b_j_base_q + SiA;
                                    b_addr_q   <= b_j_base_q + SiA;
                                end else begin
                                    j_q        <= '0;
                                    b_j_base_q <= '0;
                                    b_addr_q   <= '0;
                                    if (!i_last) begin
                                        i_q        <= i_q + N_MAX_WIDTH'(1);
                                        a_i_base_q <= a_i_base_q + tile_step_q;
                                        a_n_base_q <= a_i_base_q + tile_step_q;
                                        a_addr_q   <= a_i_base_q + tile_step_q;
                                    end else begin
                                        i_q        <= '0;
                                        a_i_base_q <= '0;
                                        a_n_base_q <= '0;
                                        a_addr_q   <= '0;
                                        state_q    <= StDrain;
                                    end
                                end
                            end
                        end
                    end
                end
                StDrain: begin
                    if ((fifo_count == 2'd0) && !ret_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    matmul_feed_fifo u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (ret_q),
        .wdata_i ('{a: a_rd_data, b: b_rd_data}),
        .ready_i (out_ready),
        .head_o  (fifo_head),
        .valid_o (A_valid_out),
        .count_o (fifo_count)
    );

    assign B_valid_out = A_valid_out;
    assign A_out       = fifo_head.a;
    assign B_out       = fifo_head.b;

`ifdef MATMUL_FEED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state_q == StIdle) && start && cfg_legal) begin
            stall_cnt <= '0;
        end else if (A_valid_out && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_feed_sched.sv
module tb_matmul_feed_sched;

    localparam logic [63:0] A_TAG = 64'hA0A0_A0A0_0000_0000;
    localparam logic [63:0] B_TAG = 64'hB0B0_B0B0_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] N_in = 32'd0;
    logic        busy, done, cfg_err;
    logic        a_rd_en, b_rd_en;
    logic [15:0] a_rd_addr, b_rd_addr;
    logic [63:0] a_rd_data = 64'd0;
    logic [63:0] b_rd_data = 64'd0;
    logic [63:0] A_out, B_out;
    logic        A_valid_out, B_valid_out;
    logic        out_ready = 1'b0;
`ifdef MATMUL_FEED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    // Memories return an address-tagged word one cycle after the strobe.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= A_TAG | {48'd0, a_rd_addr};
        if (b_rd_en) b_rd_data <= B_TAG | {48'd0, b_rd_addr};
    end

    matmul_feed_sched dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .N_in        (N_in),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .a_rd_en     (a_rd_en),
        .a_rd_addr   (a_rd_addr),
        .a_rd_data   (a_rd_data),
        .b_rd_en     (b_rd_en),
        .b_rd_addr   (b_rd_addr),
        .b_rd_data   (b_rd_data),
        .A_out       (A_out),
        .A_valid_out (A_valid_out),
        .B_out       (B_out),
        .B_valid_out (B_valid_out),
        .out_ready   (out_ready)
`ifdef MATMUL_FEED_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Reference order: plain nested loops over tile indices.
    task automatic build_exp(input int n_cfg);
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < n_cfg / 8; i++)
            for (int j = 0; j < n_cfg / 8; j++)
                for (int n = 0; n < n_cfg; n++)
                    for (int ii = 0; ii < 8; ii++) begin
                        exp_a.push_back(A_TAG | 64'((i * 8 + ii) * n_cfg + n));
                        exp_b.push_back(B_TAG | 64'(n * n_cfg + j * 8 + ii));
                    end
    endtask

    function automatic int stream_errs(output int first_bad);
        int e = 0;
        first_bad = -1;
        for (int k = 0; k < exp_a.size(); k++) begin
            if (k >= got_a.size() || got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                e++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (got_a.size() > exp_a.size()) e += got_a.size() - exp_a.size();
        return e;
    endfunction

    // Starts a run and records accepted beats; ends 3 cycles after done, after
    // stop_beats beats (if nonzero), or on the cycle budget.
    task automatic collect(input int n_cfg, input bit rand_ready, input int stop_beats,
                           input int stall_at, output int done_cnt, output int stab_err,
                           output int pair_err, output bit timed_out);
        logic [63:0] pa, pb;
        bit   stalled, trig;
        int   stall_left, after_done, cycles;
        got_a.delete();
        got_b.delete();
        done_cnt = 0; stab_err = 0; pair_err = 0; timed_out = 1'b0;
        stalled = 1'b0; trig = 1'b0; stall_left = 0; after_done = -1;
        pa = '0; pb = '0;
        N_in = 32'(n_cfg);
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cycles = 0; cycles < 20000; cycles++) begin
            if (a_rd_en !== b_rd_en || A_valid_out !== B_valid_out) pair_err++;
            if (stalled && (A_valid_out !== 1'b1 || A_out !== pa || B_out !== pb)) stab_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (after_done < 0) after_done = 0;
            end
            if (after_done >= 0) begin
                if (after_done == 3) break;
                after_done++;
            end
            if (stop_beats != 0 && got_a.size() >= stop_beats) break;
            if (!trig && stall_at >= 0 && A_valid_out === 1'b1 && got_a.size() == stall_at) begin
                trig = 1'b1;
                stall_left = 37;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (A_valid_out === 1'b1 && out_ready) begin
                got_a.push_back(A_out);
                got_b.push_back(B_out);
            end
            stalled = (A_valid_out === 1'b1) && !out_ready;
            pa = A_out;
            pb = B_out;
            @(posedge clk); #1;
        end
        if (cycles >= 20000) timed_out = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({busy, done, cfg_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_status: got %b expected 000", {busy, done, cfg_err});
        end
        tests_run++;
        if ({a_rd_en, b_rd_en, A_valid_out, B_valid_out} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {a_rd_en, b_rd_en, A_valid_out, B_valid_out});
        end
        tests_run++;
        if (a_rd_addr !== 16'd0 || b_rd_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_addr: got %0h/%0h expected 0/0", a_rd_addr, b_rd_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || a_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b rd_en=%b expected 0/0", busy, a_rd_en);
        end
    endtask

    task automatic test_cfg_err();
        int bad_n[3] = '{12, 0, 264};
        bit rd_seen;
        for (int k = 0; k < 3; k++) begin
            N_in = 32'(bad_n[k]);
            start = 1'b1;
            rd_seen = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            if (a_rd_en) rd_seen = 1'b1;
            tests_run++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_err_pulse N=%0d: got cfg_err=%b busy=%b expected 1/0",
                         bad_n[k], cfg_err, busy);
            end
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (a_rd_en || busy) rd_seen = 1'b1;
            end
            tests_run++;
            if (cfg_err !== 1'b0 || rd_seen !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_err_after N=%0d: got cfg_err=%b activity=%b expected 0/0",
                         bad_n[k], cfg_err, rd_seen);
            end
        end
    endtask

    // Start with out_ready low: check first-read/first-valid timing, then freeze.
    task automatic test_latency_stall();
        N_in = 32'd16;
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || a_rd_en !== 1'b1 || a_rd_addr !== 16'd0 || b_rd_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL first_issue: got busy=%b rd_en=%b addr=%0h/%0h expected 1/1/0/0",
                     busy, a_rd_en, a_rd_addr, b_rd_addr);
        end
        @(posedge clk); #1;
        tests_run++;
        if (A_valid_out !== 1'b0 || a_rd_addr !== 16'd16) begin
            tests_failed++;
            $display("FAIL second_cycle: got valid=%b addr=%0h expected 0/10", A_valid_out,
                     a_rd_addr);
        end
        @(posedge clk); #1;
        tests_run++;
        if (A_valid_out !== 1'b1 || A_out !== A_TAG || B_out !== B_TAG) begin
            tests_failed++;
            $display("FAIL first_valid: got valid=%b A=%0h B=%0h expected 1/%0h/%0h",
                     A_valid_out, A_out, B_out, A_TAG, B_TAG);
        end
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (A_valid_out !== 1'b1 || A_out !== A_TAG || busy !== 1'b1 || a_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL frozen: got valid=%b A=%0h busy=%b rd_en=%b expected 1/%0h/1/0",
                     A_valid_out, A_out, busy, a_rd_en, A_TAG);
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream_full();
        int dc, se, pe, fb, errs;
        bit to;
        build_exp(16);
        collect(16, 1'b0, 0, -1, dc, se, pe, to);
        tests_run++;
        if (to || got_a.size() !== 512) begin
            tests_failed++;
            $display("FAIL full_beats: got %0d (timeout=%b) expected 512", got_a.size(), to);
        end
        tests_run++;
        if (got_a.size() < 4 || got_a[1] !== (A_TAG | 64'd16) || got_a[2] !== (A_TAG | 64'd32) ||
            got_a[3] !== (A_TAG | 64'd48) || got_b[3] !== (B_TAG | 64'd3)) begin
            tests_failed++;
            $display("FAIL first_beats: beats 1..3 addresses wrong, expected A 16,32,48 B 3");
        end
        tests_run++;
        if (got_a.size() < 129 || got_a[128] !== A_TAG || got_b[128] !== (B_TAG | 64'd8)) begin
            tests_failed++;
            $display("FAIL beat128: expected A %0h B %0h", A_TAG, B_TAG | 64'd8);
        end
        errs = stream_errs(fb);
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL full_order: got %0d bad beats (first %0d) expected 0", errs, fb);
        end
        tests_run++;
        if (dc !== 1 || busy !== 1'b0 || pe !== 0) begin
            tests_failed++;
            $display("FAIL full_done: got done_cnt=%0d busy=%b pair_err=%0d expected 1/0/0",
                     dc, busy, pe);
        end
    endtask

    task automatic test_random_ready();
        int dc, se, pe, fb, errs;
        bit to;
        build_exp(16);
        collect(16, 1'b1, 0, -1, dc, se, pe, to);
        errs = stream_errs(fb);
        tests_run++;
        if (to || errs !== 0 || got_a.size() !== 512) begin
            tests_failed++;
            $display("FAIL random_order: got %0d beats, %0d bad (first %0d) expected 512/0",
                     got_a.size(), errs, fb);
        end
        tests_run++;
        if (se !== 0 || pe !== 0) begin
            tests_failed++;
            $display("FAIL random_stable: got stab_err=%0d pair_err=%0d expected 0/0", se, pe);
        end
        tests_run++;
        if (dc !== 1) begin
            tests_failed++;
            $display("FAIL random_done: got %0d expected 1", dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc, se, pe, fb, errs;
        bit to;
        collect(16, 1'b0, 100, -1, dc, se, pe, to);
        tests_run++;
        if (to || got_a.size() !== 100 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: got %0d beats busy=%b expected 100/1", got_a.size(), busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, A_valid_out, a_rd_en, done} !== 4'b0000 || a_rd_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b addr=%0h expected 0000/0",
                     {busy, A_valid_out, a_rd_en, done}, a_rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_exp(8);
        collect(8, 1'b0, 0, -1, dc, se, pe, to);
        errs = stream_errs(fb);
        tests_run++;
        if (to || got_a.size() !== 64 || errs !== 0) begin
            tests_failed++;
            $display("FAIL post_reset_run: got %0d beats, %0d bad (first %0d) expected 64/0",
                     got_a.size(), errs, fb);
        end
        tests_run++;
        if (got_a.size() == 0 || got_a[0] !== A_TAG || dc !== 1) begin
            tests_failed++;
            $display("FAIL post_reset_first: expected A %0h and one done, got done_cnt=%0d",
                     A_TAG, dc);
        end
    endtask

`ifdef MATMUL_FEED_PERF_EN
    task automatic test_perf_stall();
        int dc, se, pe, fb, errs;
        bit to;
        build_exp(8);
        collect(8, 1'b0, 0, 20, dc, se, pe, to);
        errs = stream_errs(fb);
        tests_run++;
        if (to || errs !== 0 || se !== 0) begin
            tests_failed++;
            $display("FAIL perf_stream: got %0d bad beats stab_err=%0d expected 0/0", errs, se);
        end
        tests_run++;
        if (stall_cnt !== 32'd37) begin
            tests_failed++;
            $display("FAIL perf_stall_cnt: got %0d expected 37", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_err();
        test_latency_stall();
        test_stream_full();
        test_random_ready();
        test_reset_mid();
`ifdef MATMUL_FEED_PERF_EN
        test_perf_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
